// File: rtl/neuro_nav_pkg.sv
// Shared register map, CTRL field positions and saturating arithmetic helpers
// for the neuromorphic odometry peripheral.
package neuro_nav_pkg;

   localparam logic [5:0] ADDR_CTRL     = 6'h00;
   localparam logic [5:0] ADDR_MOVE     = 6'h04;
   localparam logic [5:0] ADDR_POS01    = 6'h08;
   localparam logic [5:0] ADDR_POS23    = 6'h0C;
   localparam logic [5:0] ADDR_BOUND    = 6'h10;
   localparam logic [5:0] ADDR_STATUS   = 6'h14;
   localparam logic [5:0] ADDR_FIRE_CNT = 6'h18;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_CLR_BIT  = 1;
   localparam int CTRL_LEAK_LSB = 4;
   localparam int CTRL_TH_LSB   = 8;
   localparam int CTRL_W_LSB    = 16;
   localparam int CTRL_IRQ_LSB  = 24;

   // Wide enough for a 16-bit position plus a 16-bit signed delta without overflow.
   localparam int ARITH_W = 20;

   function automatic logic [ARITH_W-1:0] sat_add_sub(input logic [ARITH_W-1:0] a,
                                                     input logic [ARITH_W-1:0] b,
                                                     input logic dec,
                                                     input int w);
      logic [ARITH_W-1:0] s;
      logic [ARITH_W-1:0] max_v;
      max_v = (20'd1 << w) - 20'd1;
      s     = a + b;
      if (dec) begin
         s = (s != 20'd0) ? (s - 20'd1) : 20'd0;
      end
      if (s > max_v) begin
         s = max_v;
      end
      return s;
   endfunction

   function automatic logic [ARITH_W-1:0] clamp_signed(input logic signed [ARITH_W-1:0] v,
                                                      input int w);
      logic signed [ARITH_W-1:0] max_v;
      max_v = (20'sd1 <<< w) - 20'sd1;
      if (v < 20'sd0) begin
         return 20'd0;
      end else if (v > max_v) begin
         return $unsigned(max_v);
      end else begin
         return $unsigned(v);
      end
   endfunction

endpackage

// File: rtl/neuro_lif_neuron.sv
// One leaky integrate-and-fire neuron: saturating membrane, registered fire pulse.
module neuro_lif_neuron
   import neuro_nav_pkg::*;
#(
   parameter int MEM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             spike_edge,
   input  logic             leak_tick,
   input  logic [MEM_W-1:0] weight,
   input  logic [MEM_W-1:0] fire_th,
   output logic             fire
);

   logic [MEM_W-1:0] mem_r;
   logic [MEM_W-1:0] sum_s;
   logic             hit_s;

   // Membrane candidate and threshold compare; a zero threshold never fires.
   always_comb begin
      sum_s = MEM_W'(sat_add_sub(ARITH_W'(mem_r),
                                 spike_edge ? ARITH_W'(weight) : {ARITH_W{1'b0}},
                                 leak_tick, MEM_W));
      hit_s = (fire_th != {MEM_W{1'b0}}) && (sum_s >= fire_th);
   end

   // Membrane and fire register; clear beats evaluation, disable holds the membrane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r <= {MEM_W{1'b0}};
         fire  <= 1'b0;
      end else if (clr) begin
         mem_r <= {MEM_W{1'b0}};
         fire  <= 1'b0;
      end else if (en && hit_s) begin
         mem_r <= {MEM_W{1'b0}};
         fire  <= 1'b1;
      end else if (en) begin
         mem_r <= sum_s;
         fire  <= 1'b0;
      end else begin
         fire  <= 1'b0;
      end
   end

endmodule

// File: rtl/tqvp_neuro_odom_lif.sv
// TinyQV odometry peripheral: spike lines drive LIF neurons whose fires step
// saturating per-axis positions; register file, prescaler and bound interrupts.
module tqvp_neuro_odom_lif
   import neuro_nav_pkg::*;
#(
   parameter int NUM_AXES = 2,
   parameter int POS_W    = 16,
   parameter int MEM_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   localparam int NL = 2 * NUM_AXES;

   logic        en_r;
   logic        clear_r;
   logic [3:0]  leak_div_r;
   logic [7:0]  fire_th_r;
   logic [7:0]  weight_r;
   logic [3:0]  irq_en_r;
   logic [31:0] move_r;
   logic [15:0] bound_r;
   logic [3:0]  pending_r;
   logic        irq_r;
   logic [15:0] fire_cnt_r;
   logic [15:0] presc_r;

   logic [NL-1:0] sync1_r, sync2_r, sync3_r, edge_r, fire_s;
   logic [POS_W-1:0] pos_r      [NUM_AXES];
   logic [POS_W-1:0] pos_next_s [NUM_AXES];
   logic [15:0]      pos_view_s [4];

   logic wr_s, wr_ctrl_s, wr_move_s, wr_bound_s, wr_status_s, wr_fcnt_s;
   logic        leak_tick_s;
   logic [15:0] leak_mask_s;
   logic [3:0]  pend_next_s;
   logic [15:0] fire_pop_s;
   logic signed [ARITH_W-1:0] acc_s;
   logic unused_s;

   assign wr_s        = (data_write_n != 2'b11);
   assign wr_ctrl_s   = wr_s && (address == ADDR_CTRL);
   assign wr_move_s   = wr_s && (address == ADDR_MOVE);
   assign wr_bound_s  = wr_s && (address == ADDR_BOUND);
   assign wr_status_s = wr_s && (address == ADDR_STATUS);
   assign wr_fcnt_s   = wr_s && (address == ADDR_FIRE_CNT);
   assign data_ready  = 1'b1;
   assign user_interrupt = irq_r;
   assign unused_s    = &{1'b0, data_read_n, ui_in, data_in};

   // Leak strobe: once every 2^leak_div cycles of the free-running prescaler.
   always_comb begin
      leak_mask_s = (16'd1 << leak_div_r) - 16'd1;
      leak_tick_s = (leak_div_r != 4'd0) && ((presc_r & leak_mask_s) == 16'd0);
   end

   // Two-flop synchroniser and registered rising-edge detect; runs even while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= {NL{1'b0}};
         sync2_r <= {NL{1'b0}};
         sync3_r <= {NL{1'b0}};
         edge_r  <= {NL{1'b0}};
      end else begin
         sync1_r <= ui_in[NL-1:0];
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
         edge_r  <= sync2_r & ~sync3_r;
      end
   end

   for (genvar i = 0; i < NL; i++) begin : g_neuron
      neuro_lif_neuron #(
         .MEM_W(MEM_W)
      ) u_neuron (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (en_r),
         .clr       (clear_r),
         .spike_edge(edge_r[i]),
         .leak_tick (leak_tick_s),
         .weight    (MEM_W'(weight_r)),
         .fire_th   (MEM_W'(fire_th_r)),
         .fire      (fire_s[i])
      );
   end

   // Next position per axis: fires plus any MOVE delta for this axis, clamped.
   always_comb begin
      acc_s = {ARITH_W{1'b0}};
      for (int k = 0; k < NUM_AXES; k++) begin
         acc_s = $signed(ARITH_W'(pos_r[k])) + $signed(ARITH_W'(fire_s[2*k]))
               - $signed(ARITH_W'(fire_s[2*k+1]));
         if (wr_move_s && (data_in[17:16] == 2'(k))) begin
            acc_s = acc_s + ARITH_W'($signed(data_in[15:0]));
         end else begin
            acc_s = acc_s;
         end
         pos_next_s[k] = POS_W'(clamp_signed(acc_s, POS_W));
      end
   end

   // Position accumulators; clear overrides fires and MOVE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_AXES; k++) pos_r[k] <= {POS_W{1'b0}};
      end else if (clear_r) begin
         for (int k = 0; k < NUM_AXES; k++) pos_r[k] <= {POS_W{1'b0}};
      end else if (en_r) begin
         for (int k = 0; k < NUM_AXES; k++) pos_r[k] <= pos_next_s[k];
      end else begin
         for (int k = 0; k < NUM_AXES; k++) pos_r[k] <= pos_r[k];
      end
   end

   // Zero-extended view of all four axis slots, absent axes reading 0.
   always_comb begin
      for (int k = 0; k < 4; k++) pos_view_s[k] = 16'd0;
      for (int k = 0; k < NUM_AXES; k++) pos_view_s[k] = 16'(pos_r[k]);
   end

   // Sticky pending bits (set beats clear) and fire population count.
   always_comb begin
      pend_next_s = 4'd0;
      for (int k = 0; k < NUM_AXES; k++) begin
         pend_next_s[k] = (pos_view_s[k] > bound_r) ||
                          (pending_r[k] && !(wr_status_s && data_in[k]));
      end
      fire_pop_s = 16'd0;
      for (int i = 0; i < NL; i++) fire_pop_s = fire_pop_s + 16'(fire_s[i]);
   end

   // Writable registers; clear is a one-cycle strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_r       <= 1'b0;
         clear_r    <= 1'b0;
         leak_div_r <= 4'd0;
         fire_th_r  <= 8'd0;
         weight_r   <= 8'd0;
         irq_en_r   <= 4'd0;
         move_r     <= 32'd0;
         bound_r    <= 16'd0;
      end else begin
         clear_r <= wr_ctrl_s && data_in[CTRL_CLR_BIT];
         if (wr_ctrl_s) begin
            en_r       <= data_in[CTRL_EN_BIT];
            leak_div_r <= data_in[CTRL_LEAK_LSB +: 4];
            fire_th_r  <= data_in[CTRL_TH_LSB +: 8];
            weight_r   <= data_in[CTRL_W_LSB +: 8];
            irq_en_r   <= data_in[CTRL_IRQ_LSB +: 4];
         end
         if (wr_move_s)  move_r  <= data_in;
         if (wr_bound_s) bound_r <= data_in[15:0];
      end
   end

   // Status, interrupt output, fire counter and prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r  <= 4'd0;
         irq_r      <= 1'b0;
         fire_cnt_r <= 16'd0;
         presc_r    <= 16'd0;
      end else begin
         pending_r  <= pend_next_s;
         irq_r      <= |(pending_r & irq_en_r);
         fire_cnt_r <= wr_fcnt_s ? 16'd0 : (fire_cnt_r + fire_pop_s);
         presc_r    <= presc_r + 16'd1;
      end
   end

   // Combinational register readback.
   always_comb begin
      data_out = 32'd0;
      case (address)
         ADDR_CTRL:     data_out = {4'd0, irq_en_r, weight_r, fire_th_r, leak_div_r, 3'd0, en_r};
         ADDR_MOVE:     data_out = move_r;
         ADDR_POS01:    data_out = {pos_view_s[1], pos_view_s[0]};
         ADDR_POS23:    data_out = {pos_view_s[3], pos_view_s[2]};
         ADDR_BOUND:    data_out = {16'd0, bound_r};
         ADDR_STATUS:   data_out = {28'd0, pending_r};
         ADDR_FIRE_CNT: data_out = {16'd0, fire_cnt_r};
         default:       data_out = 32'd0;
      endcase
   end

   assign uo_out = {pos_view_s[1][3:0], pos_view_s[0][3:0]};

endmodule

// File: tb/tb_tqvp_neuro_odom_lif.sv
// Scoreboard bench: a behavioural model predicts readback, uo_out and the
// interrupt; a monitor compares them against the DUT at the falling edge.
`timescale 1ns/1ps
module tb_tqvp_neuro_odom_lif;

   localparam int NA = 2;
   localparam int NL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  ui_in = 8'd0;
   logic [7:0]  uo_out;
   logic [5:0]  address = 6'd0;
   logic [31:0] data_in = 32'd0;
   logic [1:0]  data_write_n = 2'b11;
   logic [1:0]  data_read_n = 2'b11;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   always #5 clk = ~clk;

   tqvp_neuro_odom_lif dut (
      .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
      .address(address), .data_in(data_in), .data_write_n(data_write_n),
      .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
      .user_interrupt(user_interrupt)
   );

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sb[$];
   int  checks = 0;
   int  failures = 0;
   bit  chk_req = 1'b0;

   // Reference model state
   logic [15:0] m_pos [NA];
   int          m_mem [NL];
   logic [NL-1:0] m_fire;
   logic [7:0]  h1, h2, h3, h4;
   bit          m_en, m_clear, m_irq;
   int          m_ld, m_th, m_w, m_bound, m_fcnt, m_cyc;
   logic [3:0]  m_ie, m_pend;
   logic [31:0] m_move;

   task automatic model_reset();
      for (int k = 0; k < NA; k++) m_pos[k] = 16'd0;
      for (int i = 0; i < NL; i++) m_mem[i] = 0;
      m_fire = '0; h1 = 8'd0; h2 = 8'd0; h3 = 8'd0; h4 = 8'd0;
      m_en = 1'b0; m_clear = 1'b0; m_irq = 1'b0;
      m_ld = 0; m_th = 0; m_w = 0; m_bound = 0; m_fcnt = 0; m_cyc = 0;
      m_ie = 4'd0; m_pend = 4'd0; m_move = 32'd0;
   endtask

   task automatic model_step();
      bit wr;
      bit tick;
      logic [7:0] e;
      int nmem [NL];
      logic [NL-1:0] nfire;
      logic [15:0] npos [NA];
      logic [3:0] npend;
      int s, d, nf;
      wr   = (data_write_n != 2'b11);
      tick = (m_ld != 0) && ((m_cyc % (1 << m_ld)) == 0);
      e    = h3 & ~h4;
      for (int i = 0; i < NL; i++) begin
         nmem[i] = m_mem[i];
         nfire[i] = 1'b0;
         if (m_clear) begin
            nmem[i] = 0;
         end else if (m_en) begin
            s = m_mem[i] + (e[i] ? m_w : 0) - (tick ? 1 : 0);
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            if (m_th != 0 && s >= m_th) begin
               nfire[i] = 1'b1;
               nmem[i] = 0;
            end else begin
               nmem[i] = s;
            end
         end
      end
      for (int k = 0; k < NA; k++) begin
         npos[k] = m_pos[k];
         if (m_clear) begin
            npos[k] = 16'd0;
         end else if (m_en) begin
            s = int'(m_pos[k]) + int'(m_fire[2*k]) - int'(m_fire[2*k+1]);
            if (wr && address == 6'h04 && int'(data_in[17:16]) == k) begin
               d = int'($signed(data_in[15:0]));
               s = s + d;
            end
            if (s < 0) s = 0;
            if (s > 65535) s = 65535;
            npos[k] = 16'(s);
         end
      end
      npend = 4'd0;
      for (int k = 0; k < NA; k++)
         npend[k] = (int'(m_pos[k]) > m_bound) ||
                    (m_pend[k] && !(wr && address == 6'h14 && data_in[k]));
      nf = 0;
      for (int i = 0; i < NL; i++) nf += int'(m_fire[i]);
      m_irq  = |(m_pend & m_ie);
      m_fcnt = (wr && address == 6'h18) ? 0 : ((m_fcnt + nf) % 65536);
      m_clear = wr && address == 6'h00 && data_in[1];
      if (wr && address == 6'h00) begin
         m_en = data_in[0]; m_ld = int'(data_in[7:4]); m_th = int'(data_in[15:8]);
         m_w = int'(data_in[23:16]); m_ie = data_in[27:24];
      end
      if (wr && address == 6'h04) m_move = data_in;
      if (wr && address == 6'h10) m_bound = int'(data_in[15:0]);
      m_pend = npend;
      for (int i = 0; i < NL; i++) m_mem[i] = nmem[i];
      m_fire = nfire;
      for (int k = 0; k < NA; k++) m_pos[k] = npos[k];
      h4 = h3; h3 = h2; h2 = h1; h1 = ui_in;
      m_cyc = (m_cyc + 1) % 65536;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   function automatic logic [31:0] exp_read(input logic [5:0] a);
      case (a)
         6'h00:   return {4'd0, m_ie, 8'(m_w), 8'(m_th), 4'(m_ld), 3'd0, m_en};
         6'h04:   return m_move;
         6'h08:   return {m_pos[1], m_pos[0]};
         6'h10:   return 32'(m_bound);
         6'h14:   return {28'd0, m_pend};
         6'h18:   return 32'(m_fcnt);
         default: return 32'd0;
      endcase
   endfunction

   // Monitor: compare every queued expectation against what the DUT presents.
   always @(negedge clk) begin
      if (chk_req) begin
         while (sb.size() > 0) begin
            sb_t ent;
            logic [31:0] act;
            ent = sb.pop_front();
            act = (ent.kind == 0) ? data_out :
                  (ent.kind == 1) ? {24'd0, uo_out} : {31'd0, user_interrupt};
            checks++;
            if (act !== ent.exp) begin
               failures++;
               $display("FAIL %s actual=0x%0h expected=0x%0h", ent.name, act, ent.exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      address = a; data_in = d; data_write_n = 2'b00;
      step();
      data_write_n = 2'b11;
   endtask

   task automatic chk_reg(input logic [5:0] a, input string nm);
      address = a;
      sb.push_back('{0, exp_read(a), nm});
      chk_req = 1'b1;
      step();
      chk_req = 1'b0;
   endtask

   task automatic chk_io(input string nm);
      sb.push_back('{1, {24'd0, m_pos[1][3:0], m_pos[0][3:0]}, {nm, "_uo"}});
      sb.push_back('{2, {31'd0, m_irq}, {nm, "_irq"}});
      chk_req = 1'b1;
      step();
      chk_req = 1'b0;
   endtask

   task automatic chk_all(input string nm);
      for (int a = 0; a < 8; a++) chk_reg(6'(a * 4), $sformatf("%s_reg%0h", nm, a * 4));
      chk_io(nm);
   endtask

   function automatic logic [31:0] ctrl_val(input bit en, input bit clr, input int ld,
                                            input int th, input int w, input int ie);
      return {4'd0, 4'(ie), 8'(w), 8'(th), 4'(ld), 2'd0, clr, en};
   endfunction

   function automatic logic [31:0] mv(input int axis, input int delta);
      return {14'd0, 2'(axis), 16'(delta)};
   endfunction

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk_all("reset");

      // Three edges; fire on the third
      wr(6'h00, ctrl_val(1, 0, 0, 10, 4, 0));
      for (int n = 0; n < 3; n++) begin
         ui_in[0] = 1'b1; step(); step();
         ui_in[0] = 1'b0; step(); step();
         chk_reg(6'h08, $sformatf("t1_pos_pre%0d", n));
         chk_reg(6'h08, $sformatf("t1_pos_post%0d", n));
         repeat (3) step();
      end
      chk_reg(6'h18, "t1_fire_cnt");
      chk_io("t1");

      // Leak: widely spaced edges decay away, closely spaced ones fire
      wr(6'h00, ctrl_val(1, 0, 2, 8, 4, 0));
      for (int n = 0; n < 2; n++) begin
         ui_in[2] = 1'b1; step(); ui_in[2] = 1'b0;
         repeat (19) step();
      end
      repeat (10) step();
      chk_reg(6'h08, "leak_slow_pos");
      repeat (20) step();
      while ((m_cyc % 4) != 2) step();
      ui_in[2] = 1'b1; step(); ui_in[2] = 1'b0; step(); ui_in[2] = 1'b1; step(); ui_in[2] = 1'b0;
      repeat (6) step();
      chk_reg(6'h08, "leak_fast_pos");

      // MOVE clamping
      wr(6'h00, ctrl_val(1, 1, 0, 0, 4, 0));
      step();
      wr(6'h04, mv(0, 3));
      wr(6'h04, mv(0, -5));
      chk_reg(6'h08, "move_clamp_lo");
      wr(6'h04, mv(0, 32767)); wr(6'h04, mv(0, 32767)); wr(6'h04, mv(0, 32767));
      chk_reg(6'h08, "move_clamp_hi");
      wr(6'h04, mv(2, 5));
      chk_reg(6'h04, "move_readback");
      chk_reg(6'h08, "move_absent_axis");

      // Bound interrupt
      wr(6'h00, ctrl_val(1, 1, 0, 0, 4, 1));
      wr(6'h10, 32'd100);
      wr(6'h04, mv(0, 101));
      repeat (3) step();
      chk_reg(6'h14, "irq_set");
      chk_io("irq_set");
      wr(6'h14, 32'd1);
      chk_reg(6'h14, "irq_set_wins");
      wr(6'h04, mv(0, -50));
      step(); step();
      wr(6'h14, 32'd1);
      step(); step();
      chk_reg(6'h14, "irq_cleared");
      chk_io("irq_cleared");

      // Opposing fires cancel; clear beats MOVE
      wr(6'h00, ctrl_val(1, 1, 0, 4, 4, 0));
      wr(6'h04, mv(0, 5));
      ui_in[1:0] = 2'b11; step(); step(); ui_in[1:0] = 2'b00;
      repeat (6) step();
      chk_reg(6'h08, "cancel_pos");
      chk_reg(6'h18, "cancel_fire_cnt");
      wr(6'h00, ctrl_val(1, 1, 0, 4, 4, 0));
      wr(6'h04, mv(0, 7));
      step();
      chk_reg(6'h08, "clear_beats_move");
      chk_reg(6'h00, "ctrl_readback");

      // Randomised traffic
      wr(6'h00, ctrl_val(1, 0, 2, 6, 3, 3));
      wr(6'h10, 32'd40);
      for (int it = 0; it < 400; it++) begin
         int r;
         ui_in = ui_in ^ 8'($urandom & $urandom & 32'h0F);
         r = int'($urandom_range(0, 19));
         case (r)
            0: wr(6'h04, mv(int'($urandom_range(0, 3)), int'($urandom_range(0, 400)) - 200));
            1: wr(6'h00, ctrl_val(1, 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                                  int'($urandom_range(1, 8)), 3));
            2: chk_reg(6'h08, "rand_pos");
            3: chk_reg(6'h18, "rand_fire_cnt");
            4: chk_reg(6'h14, "rand_status");
            5: chk_io("rand");
            6: wr(6'h14, 32'hF);
            7: wr(6'h10, 32'($urandom_range(0, 300)));
            8: wr(6'h00, ctrl_val(1, 1, 1, 5, 3, 3));
            default: step();
         endcase
      end
      ui_in = 8'd0;
      repeat (8) step();
      chk_all("rand_end");

      // Reset with a fire in flight
      wr(6'h00, ctrl_val(1, 0, 0, 4, 4, 1));
      wr(6'h04, mv(0, 9));
      ui_in[0] = 1'b1; step(); step();
      rst_n = 1'b0;
      #1;
      chk_io("rst_during");
      rst_n = 1'b1;
      ui_in[0] = 1'b0;
      repeat (6) step();
      chk_all("rst_after");

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain actual=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
